// File: rtl/mips_alu_bist.sv
// Self-test sequencer for the MIPS ALU: drives op/operand vectors,
// checks result and zero flag against a reference model, reports status.
module mips_alu_bist #(
  parameter int          NUM_VECTORS = 64,
  parameter logic [31:0] SEED        = 32'hACE1_2345
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic        first_fail_valid,
  output logic [15:0] first_fail_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] MASK     = 32'h8020_0003;
  localparam logic [15:0] LAST     = 16'(NUM_VECTORS - 1);
  localparam logic [31:0] FIX_A    = 32'h0000_00FE;
  localparam logic [31:0] FIX_B    = 32'h0000_00F0;

  function automatic logic [31:0] step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? MASK : 32'h0);
  endfunction

  function automatic logic [3:0] op_of(input logic [2:0] k);
    case (k)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b0111;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic logic [31:0] ref_of(input logic [3:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return {31'b0, ($signed(a) < $signed(b))};
      4'b1100: return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  state_t      state, state_n;
  logic [15:0] idx, idx_n;
  logic [2:0]  opsel, opsel_n;
  logic [31:0] lfsr, lfsr_n;
  logic [3:0]  ctl_n;
  logic [31:0] a_n, b_n;
  logic        busy_n, done_n, pass_n, ffv_n;
  logic [15:0] err_n, ffi_n;
  logic [31:0] expected;
  logic        miss;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      idx              <= 16'h0;
      opsel            <= 3'd0;
      lfsr             <= SEED_EFF;
      alu_ctl          <= 4'b0000;
      alu_a            <= 32'h0;
      alu_b            <= 32'h0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 16'h0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 16'h0;
    end else begin
      state            <= state_n;
      idx              <= idx_n;
      opsel            <= opsel_n;
      lfsr             <= lfsr_n;
      alu_ctl          <= ctl_n;
      alu_a            <= a_n;
      alu_b            <= b_n;
      busy             <= busy_n;
      done             <= done_n;
      pass             <= pass_n;
      err_count        <= err_n;
      first_fail_valid <= ffv_n;
      first_fail_idx   <= ffi_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    opsel_n  = opsel;
    lfsr_n   = lfsr;
    ctl_n    = alu_ctl;
    a_n      = alu_a;
    b_n      = alu_b;
    busy_n   = busy;
    done_n   = done;
    pass_n   = pass;
    err_n    = err_count;
    ffv_n    = first_fail_valid;
    ffi_n    = first_fail_idx;
    expected = ref_of(alu_ctl, alu_a, alu_b);
    miss     = (alu_out != expected) ||
               (alu_zero != (expected == 32'h0));
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = DRIVE;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          err_n   = 16'h0;
          ffv_n   = 1'b0;
          ffi_n   = 16'h0;
          lfsr_n  = SEED_EFF;
          idx_n   = 16'h0;
          opsel_n = 3'd0;
          ctl_n   = op_of(3'd0);
          a_n     = FIX_A;
          b_n     = FIX_B;
        end
      end
      DRIVE: state_n = CHECK;
      CHECK: begin
        if (miss) begin
          if (err_count != 16'hFFFF) err_n = err_count + 16'd1;
          if (!first_fail_valid) begin
            ffv_n = 1'b1;
            ffi_n = idx;
          end
        end
        if (idx == LAST) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == 16'h0);
        end else begin
          state_n = DRIVE;
          idx_n   = idx + 16'd1;
          opsel_n = (opsel == 3'd5) ? 3'd0 : opsel + 3'd1;
          ctl_n   = op_of(opsel_n);
          // the LFSR only runs once the fixed vectors are exhausted
          if (idx_n < 16'd6) begin
            a_n = FIX_A;
            b_n = FIX_B;
          end else begin
            a_n    = lfsr;
            b_n    = step(lfsr);
            lfsr_n = step(step(lfsr));
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
